// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: one digit per REFRESH_DIV clocks, new data staged
// through a valid/ready slot and committed only at frame boundaries. Optional macro: SSD_LZ_BLANK_EN.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 131072,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    data_valid_i,
    output logic                    data_ready_o,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              segment_o,
    output logic                    dp_o,
    output logic                    frame_o
);
    // state    | meaning
    // ST_EMPTY | staging slot free, data_ready_o high
    // ST_PEND  | staged data waiting for the next frame boundary

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0]         PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [6:0]            SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = ACTIVE_LOW;

    typedef enum logic {
        ST_EMPTY,
        ST_PEND
    } hs_state_t;

    hs_state_t               state;
    logic [PW-1:0]           prescale;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] stage_data;
    logic [NUM_DIGITS-1:0]   stage_dp;

    logic                    tick;
    logic                    boundary;
    logic [IW-1:0]           idx_next;
    logic [4*NUM_DIGITS-1:0] src_data;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   lz_show;
    logic [3:0]              nibble;
    logic                    show;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [6:0]              seg_al;
    logic                    dp_al;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic [6:0]              segment_n;
    logic                    dp_n;

    // Active-low segment patterns {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h01;
            4'h1: return 7'h4F;
            4'h2: return 7'h12;
            4'h3: return 7'h06;
            4'h4: return 7'h4C;
            4'h5: return 7'h24;
            4'h6: return 7'h20;
            4'h7: return 7'h0F;
            4'h8: return 7'h00;
            4'h9: return 7'h04;
            4'hA: return 7'h08;
            4'hB: return 7'h60;
            4'hC: return 7'h31;
            4'hD: return 7'h42;
            4'hE: return 7'h30;
            default: return 7'h38;
        endcase
    endfunction

    assign tick         = (prescale == PRE_LAST);
    assign boundary     = tick && (idx == IDX_LAST);
    assign data_ready_o = (state == ST_EMPTY);

    // The first digit of a new frame must already see the data being committed on this edge.
    always_comb begin
        idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (boundary && (state == ST_PEND)) begin
            src_data = stage_data;
            src_dp   = stage_dp;
        end else begin
            src_data = disp_data;
            src_dp   = disp_dp;
        end
    end

`ifdef SSD_LZ_BLANK_EN
    always_comb begin
        logic seen;
        seen    = 1'b0;
        lz_show = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (src_data[4*k +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            lz_show[k] = seen;
        end
        lz_show[0] = 1'b1;
    end
`else
    always_comb begin
        lz_show = {NUM_DIGITS{1'b1}};
    end
`endif

    always_comb begin
        nibble         = src_data[{idx_next, 2'b00} +: 4];
        show           = ~blank_i[idx_next] & lz_show[idx_next];
        onehot         = '0;
        onehot[idx_next] = show;
        seg_al         = show ? seg_decode(nibble) : 7'h7F;
        dp_al          = ~(show & src_dp[idx_next]);
        anode_n        = ACTIVE_LOW ? ~onehot : onehot;
        segment_n      = ACTIVE_LOW ? seg_al : ~seg_al;
        dp_n           = ACTIVE_LOW ? dp_al : ~dp_al;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_EMPTY;
            prescale   <= '0;
            idx        <= '0;
            disp_data  <= '0;
            disp_dp    <= '0;
            stage_data <= '0;
            stage_dp   <= '0;
            anode_o    <= ANODE_OFF;
            segment_o  <= SEG_OFF;
            dp_o       <= DP_OFF;
            frame_o    <= 1'b0;
        end else begin
            frame_o  <= boundary;
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick) begin
                idx       <= idx_next;
                anode_o   <= anode_n;
                segment_o <= segment_n;
                dp_o      <= dp_n;
            end
            case (state)
                ST_EMPTY: begin
                    if (data_valid_i) begin
                        stage_data <= data_i;
                        stage_dp   <= dp_i;
                        state      <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (boundary) begin
                        disp_data <= stage_data;
                        disp_dp   <= stage_dp;
                        state     <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (4 digits, 4-clock refresh, active-low); cycle-count
// reference model plus table vectors and hand sequences. Honours SSD_LZ_BLANK_EN when defined.
module tb_ssd_scan_ctrl;
    localparam int N = 4;
    localparam int R = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   data_i = '0;
    logic [3:0]    dp_i = '0;
    logic          data_valid_i = 1'b0;
    logic          data_ready_o;
    logic [3:0]    blank_i = '0;
    logic [3:0]    anode_o;
    logic [6:0]    segment_o;
    logic          dp_o;
    logic          frame_o;

    ssd_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_i(rst_i), .data_i(data_i), .dp_i(dp_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .blank_i(blank_i),
        .anode_o(anode_o), .segment_o(segment_o), .dp_o(dp_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] lut [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: everything is derived from the number of clock edges since reset.
    int          m_t;
    logic [15:0] m_disp, m_stage;
    logic [3:0]  m_dpd, m_dps;
    bit          m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_disp = '0; m_stage = '0; m_dpd = '0; m_dps = '0; m_pend = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
    endtask

    task automatic expect_digit(input int k, input logic [15:0] d, input logic [3:0] dp,
                                input logic [3:0] bl);
        bit shown;
        logic [15:0] upper;
        upper = d >> (4 * k);
        shown = !bl[k];
`ifdef SSD_LZ_BLANK_EN
        if (k != 0 && upper == 16'h0) shown = 0;
`endif
        e_an  = shown ? ~(4'b0001 << k) : 4'hF;
        e_seg = shown ? lut[upper[3:0]] : 7'h7F;
        e_dp  = !(shown && dp[k]);
    endtask

    task automatic model_edge();
        bit bnd;
        m_t++;
        bnd = (m_t % (R * N) == 0);
        if (bnd && m_pend) begin
            m_disp = m_stage; m_dpd = m_dps; m_pend = 0;
        end else if (!m_pend && data_valid_i) begin
            m_stage = data_i; m_dps = dp_i; m_pend = 1;
        end
        e_frame = bnd;
        if (m_t % R == 0) expect_digit((m_t / R) % N, m_disp, m_dpd, blank_i);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("anode", 32'(anode_o), 32'(e_an));
        check("segment", 32'(segment_o), 32'(e_seg));
        check("dp", 32'(dp_o), 32'(e_dp));
        check("frame", 32'(frame_o), 32'(e_frame));
        check("ready", 32'(data_ready_o), 32'(!m_pend));
    endtask

    // Offer data, then run until the frame in which it is on display has started.
    task automatic load_and_sync(input logic [15:0] d, input logic [3:0] dp);
        int g;
        g = 0;
        while (!data_ready_o && g < 60) begin step(); g++; end
        data_i = d; dp_i = dp; data_valid_i = 1'b1;
        step();
        data_valid_i = 1'b0;
        g = 0;
        do begin step(); g++; end while (!(frame_o && data_ready_o) && g < 60);
        check("frame_wait", 32'(frame_o && data_ready_o), 32'd1);
    endtask

    task automatic mid_reset();
        #2 rst_i = 1'b1;
        #1;
        check("rst_anode", 32'(anode_o), 32'hF);
        check("rst_segment", 32'(segment_o), 32'h7F);
        check("rst_dp", 32'(dp_o), 32'd1);
        check("rst_ready", 32'(data_ready_o), 32'd1);
        check("rst_frame", 32'(frame_o), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_i = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [15:0] an;   // {d3,d2,d1,d0}
        logic [27:0] seg;  // {d3,d2,d1,d0}
        logic [3:0]  dpo;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int nf;
        int g;
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 16'h7BDE, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, 16'h7BDE, {7'h08, 7'h60, 7'h31, 7'h42}, 4'b1111};
        vecs[2] = '{16'h1234, 4'b0001, 4'b0100, 16'h7FDE, {7'h4F, 7'h7F, 7'h06, 7'h4C}, 4'b1110};
        vecs[3] = '{16'h8F0E, 4'b1010, 4'b0001, 16'h7BDF, {7'h00, 7'h38, 7'h01, 7'h7F}, 4'b0101};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("por_anode", 32'(anode_o), 32'hF);
        check("por_segment", 32'(segment_o), 32'h7F);
        check("por_ready", 32'(data_ready_o), 32'd1);
        #1 rst_i = 1'b0;

        repeat (4) step();
`ifdef SSD_LZ_BLANK_EN
        check("zero_d1_lz", 32'(anode_o), 32'hF);
`else
        check("zero_d1", 32'(segment_o), 32'h01);
        check("zero_d1_an", 32'(anode_o), 32'hD);
`endif

        for (int v = 0; v < 4; v++) begin
            blank_i = vecs[v].blank;
            load_and_sync(vecs[v].data, vecs[v].dp);
            for (int k = 0; k < N; k++) begin
                check($sformatf("vec%0d_an%0d", v, k), 32'(anode_o), 32'(vecs[v].an[4*k +: 4]));
                check($sformatf("vec%0d_seg%0d", v, k), 32'(segment_o), 32'(vecs[v].seg[7*k +: 7]));
                check($sformatf("vec%0d_dp%0d", v, k), 32'(dp_o), 32'(vecs[v].dpo[k]));
                repeat (R) step();
            end
        end

        // Mid-frame accept: old data holds until the boundary.
        blank_i = 4'b0000;
        repeat (5) step();
        data_i = 16'hABCD; dp_i = 4'b0000; data_valid_i = 1'b1;
        step();
        data_valid_i = 1'b0;
        check("mid_ready_low", 32'(data_ready_o), 32'd0);
        g = 0;
        while (!frame_o && g < 40) begin
            check("mid_old_held", 32'(segment_o == 7'h42 && anode_o == 4'hE), 32'd0);
            step(); g++;
        end
        check("mid_new_d0", 32'(segment_o), 32'h42);
        check("mid_ready_high", 32'(data_ready_o), 32'd1);

        // Accept on the boundary tick itself: commit waits a full frame.
        g = 0;
        while (((m_t + 1) % (R * N)) != 0 && g < 40) begin step(); g++; end
        data_i = 16'h00F0; dp_i = 4'b0000; data_valid_i = 1'b1;
        step();
        data_valid_i = 1'b0;
        check("collide_frame", 32'(frame_o), 32'd1);
        check("collide_old_d0", 32'(segment_o), 32'h42);
        check("collide_pending", 32'(data_ready_o), 32'd0);
        repeat (R * N) step();
        check("collide_new_d0", 32'(segment_o), 32'h01);
        check("collide_ready", 32'(data_ready_o), 32'd1);

        nf = 0;
        repeat (64) begin step(); if (frame_o) nf++; end
        check("frame_count", 32'(nf), 32'd4);

`ifdef SSD_LZ_BLANK_EN
        load_and_sync(16'h0050, 4'b0000);
        for (int k = 0; k < N; k++) begin
            check($sformatf("lz50_an%0d", k), 32'(anode_o), 32'(k == 0 ? 4'hE : k == 1 ? 4'hD : 4'hF));
            repeat (R) step();
        end
        load_and_sync(16'h0000, 4'b1111);
        check("lz0_seg0", 32'(segment_o), 32'h01);
        for (int k = 0; k < N; k++) begin
            check($sformatf("lz0_an%0d", k), 32'(anode_o), 32'(k == 0 ? 4'hE : 4'hF));
            repeat (R) step();
        end
`endif

        // Reset in the middle of a handshake discards the staged value.
        repeat (3) step();
        data_i = 16'h9999; dp_i = 4'b1111; data_valid_i = 1'b1;
        step();
        data_valid_i = 1'b0;
        repeat (2) step();
        mid_reset();
        repeat (20) step();

        for (int i = 0; i < 400; i++) begin
            data_valid_i = ($urandom % 4) == 0;
            data_i = 16'($urandom);
            dp_i = 4'($urandom);
            if ($urandom % 16 == 0) blank_i = 4'($urandom);
            step();
            if (i == 211) mid_reset();
        end
        data_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
